// File: rtl/div_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, result held until read.
// Shares the wr/rd ready-enable handshake with the sequential multiplier.
module div_seq #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data_1,
  input  logic [DATA_WIDTH-1:0] wr_data_2,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic                  rd_ready,
  output logic                  rd_val,
  output logic [DATA_WIDTH-1:0] rd_quot,
  output logic [DATA_WIDTH-1:0] rd_rem,
  output logic                  rd_dbz
);

  localparam int unsigned W         = DATA_WIDTH;
  localparam int unsigned CNT_WIDTH = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state_q,    state_d;
  logic [W-1:0]           quot_q,     quot_d;
  logic [W:0]             rem_q,      rem_d;
  logic [W-1:0]           dvsr_q,     dvsr_d;
  logic [CNT_WIDTH-1:0]   cnt_q,      cnt_d;
  logic                   wr_ready_q, wr_ready_d;
  logic                   rd_ready_q, rd_ready_d;
  logic                   rd_val_q,   rd_val_d;
  logic [W-1:0]           rd_quot_q,  rd_quot_d;
  logic [W-1:0]           rd_rem_q,   rd_rem_d;
  logic                   rd_dbz_q,   rd_dbz_d;

  logic [W:0]             shifted;
  logic [W:0]             trial;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      quot_q     <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      cnt_q      <= '0;
      wr_ready_q <= 1'b1;
      rd_ready_q <= 1'b0;
      rd_val_q   <= 1'b0;
      rd_quot_q  <= '0;
      rd_rem_q   <= '0;
      rd_dbz_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      cnt_q      <= cnt_d;
      wr_ready_q <= wr_ready_d;
      rd_ready_q <= rd_ready_d;
      rd_val_q   <= rd_val_d;
      rd_quot_q  <= rd_quot_d;
      rd_rem_q   <= rd_rem_d;
      rd_dbz_q   <= rd_dbz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    cnt_d      = cnt_q;
    wr_ready_d = wr_ready_q;
    rd_ready_d = rd_ready_q;
    rd_val_d   = 1'b0;
    rd_quot_d  = rd_quot_q;
    rd_rem_d   = rd_rem_q;
    rd_dbz_d   = rd_dbz_q;

    // Top remainder bit is always zero after a restore step, so it falls off the shift.
    shifted = (W+1)'({rem_q, quot_q[W-1]});
    trial   = shifted - {1'b0, dvsr_q};

    unique case (state_q)
      IDLE: begin
        if (wr_en) begin
          quot_d     = wr_data_1;
          dvsr_d     = wr_data_2;
          rem_d      = '0;
          cnt_d      = '0;
          wr_ready_d = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        if (!trial[W]) begin
          rem_d  = trial;
          quot_d = {quot_q[W-2:0], 1'b1};
        end else begin
          rem_d  = shifted;
          quot_d = {quot_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == LAST_ITER) begin
          rd_quot_d  = quot_d;
          rd_rem_d   = rem_d[W-1:0];
          rd_dbz_d   = (dvsr_q == '0);
          rd_ready_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (rd_en) begin
          rd_ready_d = 1'b0;
          rd_val_d   = 1'b1;
          wr_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ready = wr_ready_q;
  assign rd_ready = rd_ready_q;
  assign rd_val   = rd_val_q;
  assign rd_quot  = rd_quot_q;
  assign rd_rem   = rd_rem_q;
  assign rd_dbz   = rd_dbz_q;

endmodule
